cmp_pipe: RTL and testbench
===========================

// Module: cmp_pipe
// PURPOSE
//  Parametrised, pipelined magnitude comparator; successor to the single-register 32-bit compare.
//  Accepts operand pairs over a valid/ready stream and returns gt/lt/eq plus max/min after a two-stage pipeline.
//  Runtime signed/unsigned mode; full backpressure.
//  Sits between datapath producers and control/sort logic needing registered compare results.
// PARAMETERS
//  WIDTH  32  operand width in bits (>=2)
//  CNT_W  16  width of each statistics counter (used only with CMP_STATS_EN)
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  rst         in   1      synchronous reset, active-low (0 = reset)
//  in_valid    in   1      operand pair valid
//  in_ready    out  1      block can accept operand pair this cycle
//  a           in   WIDTH  operand A
//  b           in   WIDTH  operand B
//  is_signed   in   1      1 = two's-complement compare, 0 = unsigned; sampled with a/b
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts result
//  gt,lt,eq    out  1      A>B, A<B, A==B for the transferred pair (exactly one set when out_valid)
//  max_o       out  WIDTH  larger operand under the sampled mode (A when equal)
//  min_o       out  WIDTH  smaller operand under the sampled mode (B when equal)
//  clr_stats   in   1      synchronous clear of counters (CMP_STATS_EN only)
//  gt_cnt,lt_cnt,eq_cnt  out  CNT_W  result counters (CMP_STATS_EN only)
// BEHAVIOUR
//  - Stage S1 registers a, b, is_signed on input transfer (in_valid && in_ready).
//  - Stage S2 registers gt/lt/eq/max_o/min_o computed from S1; S2 drives outputs.
//  - Latency: 2 cycles input transfer -> out_valid with out_ready held high; throughput 1 pair/cycle.
//  - s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational).
//  - A stage holds its data unchanged while stalled; no pair is dropped or duplicated.
//  - Output data stable while out_valid && !out_ready.
//  - Signed mode: compare as WIDTH-bit two's complement (e.g. 8'h80 < 8'h7F); unsigned: 8'h80 > 8'h7F.
//  - Mode travels with its pair; changing is_signed mid-stream affects only newly accepted pairs.
//  - Reset (rst==0 at clk edge): s1/s2 valid=0, out_valid=0, gt=lt=eq=0, max_o=min_o=0, counters=0;
//    in-flight pairs are discarded; in_ready=1 on first cycle after release. Reset wins over every event.
//  - out_valid=0 -> gt/lt/eq hold their last values (0 after reset); consumers must qualify with out_valid.
// CONFIGURATION
//  Macro CMP_STATS_EN:
//  - Defined: clr_stats, gt_cnt, lt_cnt, eq_cnt present. On each output transfer (out_valid && out_ready)
//    the counter matching the result increments by 1, saturating at 2^CNT_W-1 (never wraps).
//    clr_stats=1 zeroes all three; clear has priority over a same-cycle increment (that result not counted).
//  - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. WIDTH=8 unsigned, out_ready=1: (a=8'h05,b=8'h03) -> 2 cycles later gt=1,lt=0,eq=0,max_o=05,min_o=03.
//  2. is_signed=1, a=8'h80,b=8'h7F -> lt=1,max_o=7F; same pair is_signed=0 -> gt=1,max_o=80.
//  3. Back-to-back 4 pairs, out_ready low cycles 3-6: in_ready drops after 2 pairs buffered; all 4 results
//     emerge in order, none lost/duplicated, data stable during stall.
//  4. rst=0 for one cycle with 2 pairs in flight -> next cycle out_valid=0, outputs 0, in_ready=1; no stale result.
//  5. CMP_STATS_EN, CNT_W=2: 5 equal pairs -> eq_cnt saturates at 3; clr_stats with a transfer -> eq_cnt=0.
//  6. Random a/b/mode, random out_ready: scoreboard vs reference model; exactly one of gt/lt/eq per transfer.

Source files
------------

// File: rtl/cmp_pipe.sv
// rtl/cmp_pipe.sv - two-stage valid/ready magnitude comparator with signed/unsigned mode
// Optional saturating result counters are enabled by defining CMP_STATS_EN.

module cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o
`ifdef CMP_STATS_EN
  ,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt
`endif
);

  if (WIDTH < 2 || CNT_W < 1) begin : g_param_check
    $error("cmp_pipe: WIDTH must be >= 2 and CNT_W >= 1");
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_sgn_q;

  logic             s2_valid_q;
  logic             gt_q, lt_q, eq_q;
  logic [WIDTH-1:0] max_q, min_q;

  logic             s1_adv, s2_adv;
  logic             gt_d, lt_d, eq_d;
  logic [WIDTH-1:0] max_d, min_d;
  logic [WIDTH-1:0] a_key, b_key;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_key = {s1_a_q[WIDTH-1] ^ s1_sgn_q, s1_a_q[WIDTH-2:0]};
    b_key = {s1_b_q[WIDTH-1] ^ s1_sgn_q, s1_b_q[WIDTH-2:0]};
    gt_d  = a_key > b_key;
    lt_d  = a_key < b_key;
    eq_d  = a_key == b_key;
    max_d = lt_d ? s1_b_q : s1_a_q;
    min_d = lt_d ? s1_a_q : s1_b_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sgn_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
      max_q      <= '0;
      min_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q   <= a;
          s1_b_q   <= b;
          s1_sgn_q <= is_signed;
        end
      end
      // Result flags only load with a real pair, so they hold while the output is idle.
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          gt_q  <= gt_d;
          lt_q  <= lt_d;
          eq_q  <= eq_d;
          max_q <= max_d;
          min_q <= min_d;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign max_o     = max_q;
  assign min_o     = min_q;

`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] gt_cnt_q, lt_cnt_q, eq_cnt_q;
  logic             out_fire;

  assign out_fire = s2_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (!rst || clr_stats) begin
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
      eq_cnt_q <= '0;
    end else if (out_fire) begin
      if (gt_q && gt_cnt_q != '1) gt_cnt_q <= gt_cnt_q + 1'b1;
      if (lt_q && lt_cnt_q != '1) lt_cnt_q <= lt_cnt_q + 1'b1;
      if (eq_q && eq_cnt_q != '1) eq_cnt_q <= eq_cnt_q + 1'b1;
    end
  end

  assign gt_cnt = gt_cnt_q;
  assign lt_cnt = lt_cnt_q;
  assign eq_cnt = eq_cnt_q;
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// tb/tb_cmp_pipe.sv - vector table, directed corner sequences and random scoreboard for cmp_pipe
// Stats checks are compiled in when CMP_STATS_EN is defined.

module tb_cmp_pipe;
  localparam int W  = 8;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, is_signed, out_valid, out_ready;
  logic         gt, lt, eq;
  logic [W-1:0] a, b, max_o, min_o;
`ifdef CMP_STATS_EN
  logic          clr_stats;
  logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt;
  int            m_gt, m_lt, m_eq;
`endif

  always #5 clk = ~clk;

  cmp_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .lt(lt), .eq(eq), .max_o(max_o), .min_o(min_o)
`ifdef CMP_STATS_EN
    , .clr_stats(clr_stats), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt)
`endif
  );

  typedef struct packed {logic gt, lt, eq; logic [W-1:0] mx, mn;} res_t;
  typedef struct packed {logic [W-1:0] a, b; logic s; res_t want;} vec_t;

  int   checks = 0, errors = 0;
  res_t sb_q[$];
  int   n_out = 0;
  res_t dut_res;
  res_t stall_res;
  bit   stall_prev = 0;

  assign dut_res = {gt, lt, eq, max_o, min_o};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int   vx, vy;
    res_t r;
    if (s) begin
      vx = int'($signed(x));
      vy = int'($signed(y));
    end else begin
      vx = int'(x);
      vy = int'(y);
    end
    r.gt = (vx > vy);
    r.lt = (vx < vy);
    r.eq = (vx == vy);
    r.mx = (vx >= vy) ? x : y;
    r.mn = (vx >= vy) ? y : x;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                               input logic g, input logic l, input logic e,
                               input logic [W-1:0] mx, input logic [W-1:0] mn);
    vec_t v;
    v.a = x; v.b = y; v.s = s;
    v.want = {g, l, e, mx, mn};
    return v;
  endfunction

  // Handshakes seen at the falling edge are exactly those that complete at the next rising edge.
  always @(negedge clk) begin
    res_t want;
    if (!rst) begin
      sb_q.delete();
      stall_prev = 0;
`ifdef CMP_STATS_EN
      m_gt = 0; m_lt = 0; m_eq = 0;
`endif
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(dut_res), 32'(stall_res));
      end
`ifdef CMP_STATS_EN
      chk("gt_cnt", 32'(gt_cnt), m_gt);
      chk("lt_cnt", 32'(lt_cnt), m_lt);
      chk("eq_cnt", 32'(eq_cnt), m_eq);
`endif
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
        want = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        chk("result", 32'(dut_res), 32'(want));
        chk("one_hot", int'(gt) + int'(lt) + int'(eq), 1);
        n_out++;
`ifdef CMP_STATS_EN
        if (!clr_stats) begin
          if (want.gt && m_gt < CMAX) m_gt++;
          if (want.lt && m_lt < CMAX) m_lt++;
          if (want.eq && m_eq < CMAX) m_eq++;
        end
`endif
      end
`ifdef CMP_STATS_EN
      if (clr_stats) begin
        m_gt = 0; m_lt = 0; m_eq = 0;
      end
`endif
      if (in_valid && in_ready) sb_q.push_back(model(a, b, is_signed));
      stall_prev = out_valid && !out_ready;
      stall_res  = dut_res;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    bit ok = 0;
    in_valid = 1'b1; a = x; b = y; is_signed = s;
    for (int k = 0; k < 100 && !ok; k++) begin
      #1;
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) tick();
    tick();
    chk("drain_empty", sb_q.size(), 0);
  endtask

  vec_t vt[10];

  initial begin
    int n_base;
    vt[0] = mkv(8'h05, 8'h03, 1'b0, 1, 0, 0, 8'h05, 8'h03);
    vt[1] = mkv(8'h03, 8'h05, 1'b0, 0, 1, 0, 8'h05, 8'h03);
    vt[2] = mkv(8'h80, 8'h7F, 1'b1, 0, 1, 0, 8'h7F, 8'h80);
    vt[3] = mkv(8'h80, 8'h7F, 1'b0, 1, 0, 0, 8'h80, 8'h7F);
    vt[4] = mkv(8'h42, 8'h42, 1'b0, 0, 0, 1, 8'h42, 8'h42);
    vt[5] = mkv(8'hFF, 8'h01, 1'b1, 0, 1, 0, 8'h01, 8'hFF);
    vt[6] = mkv(8'hFF, 8'h01, 1'b0, 1, 0, 0, 8'hFF, 8'h01);
    vt[7] = mkv(8'h00, 8'h00, 1'b1, 0, 0, 1, 8'h00, 8'h00);
    vt[8] = mkv(8'h7F, 8'h80, 1'b1, 1, 0, 0, 8'h7F, 8'h80);
    vt[9] = mkv(8'hFE, 8'hFF, 1'b1, 0, 1, 0, 8'hFF, 8'hFE);

    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
`ifdef CMP_STATS_EN
    clr_stats = 1'b0;
`endif
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_outputs", 32'(dut_res), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = vt[i].a; b = vt[i].b; is_signed = vt[i].s;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1", i), 32'(out_valid), 0);
      tick();
      chk($sformatf("vec%0d_lat2", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_res", i), 32'(dut_res), 32'(vt[i].want));
      tick();
    end
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_hold", 32'(dut_res), 32'(vt[9].want));

    // Backpressure: two pairs buffered, third must wait, output frozen.
    out_ready = 1'b0;
    n_base = n_out;
    send(8'h10, 8'h20, 1'b0);
    send(8'hF0, 8'h0F, 1'b1);
    in_valid = 1'b1; a = 8'h33; b = 8'h33; is_signed = 1'b0;
    #1;
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_first", 32'(dut_res), 32'(model(8'h10, 8'h20, 1'b0)));
    tick(); tick(); tick();
    chk("bp_still_first", 32'(dut_res), 32'(model(8'h10, 8'h20, 1'b0)));
    out_ready = 1'b1;
    send(8'h33, 8'h33, 1'b0);
    send(8'h81, 8'h01, 1'b1);
    drain();
    chk("bp_count", n_out - n_base, 4);

    // Reset with two pairs in flight.
    send(8'h01, 8'h02, 1'b0);
    send(8'h09, 8'h08, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_outputs", 32'(dut_res), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    tick();
    chk("no_stale", 32'(out_valid), 0);

`ifdef CMP_STATS_EN
    for (int i = 0; i < 5; i++) send(8'h5A, 8'h5A, 1'b0);
    drain();
    chk("eq_sat", 32'(eq_cnt), 3);
    chk("gt_zero", 32'(gt_cnt), 0);
    send(8'h11, 8'h11, 1'b1);
    tick();
    chk("clr_out_valid", 32'(out_valid), 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_wins", 32'(eq_cnt), 0);
`endif

    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      is_signed = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef CMP_STATS_EN
      clr_stats = ($urandom_range(0, 31) == 0);
`endif
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
`ifdef CMP_STATS_EN
    clr_stats = 1'b0;
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
